// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame streamer.
package oled_pkg;

    // Streamer control states, listed in the order they are first visited.
    typedef enum logic [2:0] {
        S_POWER    = 3'd0,
        S_RESET    = 3'd1,
        S_WAKE     = 3'd2,
        S_LOAD_CMD = 3'd3,
        S_SEND     = 3'd4,
        S_CHECK    = 3'd5,
        S_FETCH    = 3'd6
    } state_t;

    // Bytes in one 128x64 monochrome frame (8 pages x 128 columns).
    localparam int FRAME_BYTES = 1024;

    // Panel bring-up command list length.
    localparam int INIT_LEN = 15;

    // Index 0 is sent first. The concatenation is written from the last
    // byte down to the first so that INIT_CMDS[0] is AE.
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {
        8'hAF,          // display on
        8'hA4,          // resume RAM display
        8'h7F, 8'h81,   // contrast
        8'hC8,          // COM scan reverse
        8'hA1,          // segment remap
        8'h00, 8'h20,   // horizontal addressing
        8'h14, 8'h8D,   // charge pump on
        8'h3F, 8'hA8,   // mux 64
        8'h80, 8'hD5,   // clock divide
        8'hAE           // display off
    };

endpackage

// File: rtl/oled_frame_streamer_spi.sv
// SPI mode-0 byte transmitter, MSB first. A byte takes 16*CLK_DIV clocks:
// sdin changes while sclk is low and sclk rises CLK_DIV clocks later.
module spi_byte_tx #(
    parameter logic [7:0] CLK_DIV = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       sdin
);

    logic [7:0] shift_reg;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic       half_end;

    assign half_end = (div_cnt == CLK_DIV - 8'd1);

    // Combinational so the owner can leave its send state on the very edge
    // that produces the 8th falling sclk edge, without a wasted clock.
    assign done = busy && sclk && half_end && (bit_cnt == 3'd7);

    // Bits are shifted out of the top; a finished byte leaves zeros behind,
    // so sdin idles low between bytes.
    assign sdin = shift_reg[7];

    // Half-period divider, bit counter and shifter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the block updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
            div_cnt   <= 8'd0;
            bit_cnt   <= 3'd0;
            sclk      <= 1'b0;
            busy      <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                shift_reg <= data;
                div_cnt   <= 8'd0;
                bit_cnt   <= 3'd0;
                sclk      <= 1'b0;
                busy      <= 1'b1;
            end
        end else if (!half_end) begin
            div_cnt <= div_cnt + 8'd1;
        end else begin
            div_cnt <= 8'd0;
            if (!sclk) begin
                sclk <= 1'b1;
            end else begin
                sclk      <= 1'b0;
                shift_reg <= {shift_reg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// SSD1306 128x64 frame streamer: power/reset sequencing, init command list,
// then endless 1024-byte frames fetched from the text engine over SPI.
module oled_frame_streamer
    import oled_pkg::*;
#(
    parameter logic [31:0] STARTUP_WAIT  = 32'd10000000,
    parameter logic [7:0]  CLK_DIV       = 8'd1,
    parameter int          PIXEL_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] pixel_address,
    input  logic [7:0] pixel_data,
    output logic       oled_sclk,
    output logic       oled_sdin,
    output logic       oled_cs,
    output logic       oled_dc,
    output logic       oled_reset,
    output logic       frame_done
);

    localparam logic [7:0] LAT_LAST  = 8'(PIXEL_LATENCY - 1);
    localparam logic [9:0] LAST_ADDR = 10'(FRAME_BYTES - 1);
    localparam logic [3:0] LAST_CMD  = 4'(INIT_LEN - 1);

    state_t      state;
    state_t      state_next;

    logic [31:0] wait_cnt;
    logic        wait_done;
    logic [7:0]  lat_cnt;
    logic        fetch_done;
    logic [3:0]  cmd_idx;
    logic        data_phase;

    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_done;

    assign wait_done  = (wait_cnt == STARTUP_WAIT - 32'd1);
    assign fetch_done = (lat_cnt == LAT_LAST);

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .data  (tx_data),
        .busy  (tx_busy),
        .done  (tx_done),
        .sclk  (oled_sclk),
        .sdin  (oled_sdin)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_POWER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and transmitter launch.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_data    = INIT_CMDS[cmd_idx];
        case (state)
            S_POWER: begin
                if (wait_done) state_next = S_RESET;
            end
            S_RESET: begin
                if (wait_done) state_next = S_WAKE;
            end
            S_WAKE: begin
                if (wait_done) state_next = S_LOAD_CMD;
            end
            S_LOAD_CMD: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_done) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (!data_phase && (cmd_idx != LAST_CMD)) begin
                    state_next = S_LOAD_CMD;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // The text engine has had PIXEL_LATENCY edges to follow the
                // address, so the byte on pixel_data is the one we asked for.
                if (fetch_done && !tx_busy) begin
                    tx_start   = 1'b1;
                    tx_data    = pixel_data;
                    state_next = S_SEND;
                end
            end
            default: begin
                state_next = S_POWER;
            end
        endcase
    end

    // Wait/latency counters, command index, addressing and panel control pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= 32'd0;
            lat_cnt       <= 8'd0;
            cmd_idx       <= 4'd0;
            data_phase    <= 1'b0;
            pixel_address <= 10'd0;
            oled_cs       <= 1'b1;
            oled_dc       <= 1'b0;
            oled_reset    <= 1'b1;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Registered from the next state so the panel reset pin never
            // sees decode glitches.
            oled_reset <= (state_next != S_RESET);
            case (state)
                S_POWER, S_RESET, S_WAKE: begin
                    wait_cnt <= wait_done ? 32'd0 : wait_cnt + 32'd1;
                end
                S_LOAD_CMD: begin
                    if (tx_start) begin
                        oled_cs <= 1'b0;
                        oled_dc <= 1'b0;
                    end
                end
                S_CHECK: begin
                    lat_cnt <= 8'd0;
                    if (!data_phase) begin
                        if (cmd_idx != LAST_CMD) begin
                            cmd_idx <= cmd_idx + 4'd1;
                        end else begin
                            data_phase    <= 1'b1;
                            pixel_address <= 10'd0;
                        end
                    end else begin
                        // Natural 10-bit wrap; the frame boundary is flagged
                        // on the same edge that returns the address to 0.
                        pixel_address <= pixel_address + 10'd1;
                        if (pixel_address == LAST_ADDR) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (tx_start) begin
                        oled_dc <= 1'b1;
                        lat_cnt <= 8'd0;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Self-checking bench for oled_frame_streamer: one instance at CLK_DIV=1
// exercised through a full frame and a mid-byte reset, plus a CLK_DIV=3
// instance whose SPI timing and first decoded bytes are compared.
module tb_oled_frame_streamer;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } spi_byte_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // CLK_DIV=1 instance
    logic [9:0] addr1;
    logic [7:0] pd1;
    logic       sclk1, sdin1, cs1, dc1, orst1, fd1;

    // CLK_DIV=3 instance
    logic [9:0] addr3;
    logic [7:0] pd3;
    logic       sclk3, sdin3, cs3, dc3, orst3, fd3;

    oled_frame_streamer #(
        .STARTUP_WAIT  (32'd4),
        .CLK_DIV       (8'd1),
        .PIXEL_LATENCY (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_address (addr1),
        .pixel_data    (pd1),
        .oled_sclk     (sclk1),
        .oled_sdin     (sdin1),
        .oled_cs       (cs1),
        .oled_dc       (dc1),
        .oled_reset    (orst1),
        .frame_done    (fd1)
    );

    oled_frame_streamer #(
        .STARTUP_WAIT  (32'd4),
        .CLK_DIV       (8'd3),
        .PIXEL_LATENCY (2)
    ) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixel_address (addr3),
        .pixel_data    (pd3),
        .oled_sclk     (sclk3),
        .oled_sdin     (sdin3),
        .oled_cs       (cs3),
        .oled_dc       (dc3),
        .oled_reset    (orst3),
        .frame_done    (fd3)
    );

    // Text engine model: one register stage, data = address[7:0] ^ 5A.
    always @(posedge clk) begin
        pd1 <= addr1[7:0] ^ 8'h5A;
        pd3 <= addr3[7:0] ^ 8'h5A;
    end

    logic [7:0] init_ref [15] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14,
                                  8'h20, 8'h00, 8'hA1, 8'hC8, 8'h81, 8'h7F, 8'hA4, 8'hAF};

    int total = 0;
    int bad   = 0;

    spi_byte_t exp_q [$];
    spi_byte_t got_q [$];
    spi_byte_t got3_q [$];

    // ---------------- monitor, CLK_DIV=1 instance ----------------
    int         m_bits = 0;
    logic [7:0] m_sh;
    logic       m_dc;
    logic       m_prev = 1'b0;
    int         cyc = 0, last_rise = 0;
    int         hi_run = 0, hi_min = 999, hi_max = 0;
    int         rr_min = 999, rr_max = 0;
    int         cs_err = 0, got_total = 0;
    int         fd_count = 0, fd_got = -1;
    logic [9:0] fd_addr;
    logic [9:0] prev_addr = 10'd0;
    int         hold = 0, hold_min = 99999;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_bits = 0;
            m_prev = 1'b0;
            hi_run = 0;
            hold   = 0;
            prev_addr = addr1;
        end else begin
            if (sclk1 && !m_prev) begin
                if (cs1) cs_err++;
                if (m_bits == 0) m_dc = dc1;
                else begin
                    if (cyc - last_rise < rr_min) rr_min = cyc - last_rise;
                    if (cyc - last_rise > rr_max) rr_max = cyc - last_rise;
                end
                last_rise = cyc;
                m_sh = {m_sh[6:0], sdin1};
                m_bits++;
                if (m_bits == 8) begin
                    got_q.push_back('{dc: m_dc, data: m_sh});
                    got_total++;
                    m_bits = 0;
                end
            end
            if (sclk1) hi_run++;
            else if (m_prev) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            m_prev = sclk1;
            if (fd1) begin
                fd_count++;
                fd_addr = addr1;
                fd_got  = got_total;
            end
            if (addr1 != prev_addr) begin
                if (hold < hold_min) hold_min = hold;
                hold = 1;
            end else begin
                hold++;
            end
            prev_addr = addr1;
        end
    end

    // ---------------- monitor, CLK_DIV=3 instance ----------------
    int         m3_bits = 0;
    logic [7:0] m3_sh;
    logic       m3_dc;
    logic       m3_prev = 1'b0;
    int         last3 = 0;
    int         hi3_run = 0, hi3_min = 999, hi3_max = 0;
    int         rr3_min = 999, rr3_max = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m3_bits = 0;
            m3_prev = 1'b0;
            hi3_run = 0;
        end else begin
            if (sclk3 && !m3_prev) begin
                if (m3_bits == 0) m3_dc = dc3;
                else begin
                    if (cyc - last3 < rr3_min) rr3_min = cyc - last3;
                    if (cyc - last3 > rr3_max) rr3_max = cyc - last3;
                end
                last3 = cyc;
                m3_sh = {m3_sh[6:0], sdin3};
                m3_bits++;
                if (m3_bits == 8) begin
                    got3_q.push_back('{dc: m3_dc, data: m3_sh});
                    m3_bits = 0;
                end
            end
            if (sclk3) hi3_run++;
            else if (m3_prev) begin
                if (hi3_run < hi3_min) hi3_min = hi3_run;
                if (hi3_run > hi3_max) hi3_max = hi3_run;
                hi3_run = 0;
            end
            m3_prev = sclk3;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic dc, input logic [7:0] data);
        exp_q.push_back('{dc: dc, data: data});
    endtask

    // Wait (bounded) for n decoded bytes, then pop and compare each one.
    task automatic drain(input int n, input int budget, input string tag);
        int c = 0;
        spi_byte_t g, e;
        while (got_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_count_reached"}, 32'(got_q.size() >= n), 32'd1);
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) break;
            g = got_q.pop_front();
            check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(e));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        spi_byte_t ref3 [$];
        spi_byte_t g3;
        int c;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs",    32'(cs1),   32'd1);
        check("rst_sclk",  32'(sclk1), 32'd0);
        check("rst_sdin",  32'(sdin1), 32'd0);
        check("rst_dc",    32'(dc1),   32'd0);
        check("rst_oreset", 32'(orst1), 32'd1);
        check("rst_addr",  32'(addr1), 32'd0);
        check("rst_fdone", 32'(fd1),   32'd0);

        // Power / reset / wake phases: 4 clocks each.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            check($sformatf("oled_reset_k%0d", k), 32'(orst1), 32'((k < 4) || (k >= 8)));
            check($sformatf("cs_wait_k%0d", k), 32'(cs1), 32'd1);
            @(negedge clk);
        end

        // Init list, one full frame, first byte of the second frame.
        for (int i = 0; i < 15; i++) push_exp(1'b0, init_ref[i]);
        for (int a = 0; a < 1024; a++) begin
            logic [9:0] av;
            av = 10'(a);
            push_exp(1'b1, av[7:0] ^ 8'h5A);
        end
        push_exp(1'b1, 8'h5A);
        for (int i = 0; i < 15; i++) ref3.push_back('{dc: 1'b0, data: init_ref[i]});
        ref3.push_back('{dc: 1'b1, data: 8'h5A});
        ref3.push_back('{dc: 1'b1, data: 8'h5B});
        ref3.push_back('{dc: 1'b1, data: 8'h58});

        drain(1040, 30000, "frame");

        check("frame_done_pulses",  32'(fd_count), 32'd1);
        check("frame_done_addr",    32'(fd_addr),  32'd0);
        check("frame_done_after",   32'(fd_got),   32'd1039);
        check("addr_hold_min",      32'(hold_min), 32'd19);
        check("sclk_high_min_div1", 32'(hi_min),   32'd1);
        check("sclk_high_max_div1", 32'(hi_max),   32'd1);
        check("bit_period_min_div1", 32'(rr_min),  32'd2);
        check("bit_period_max_div1", 32'(rr_max),  32'd2);
        check("cs_low_during_bits", 32'(cs_err),   32'd0);

        // CLK_DIV=3 instance: same bytes, 3-clock phases.
        check("div3_count", 32'(got3_q.size() >= 18), 32'd1);
        for (int i = 0; i < 18; i++) begin
            if (got3_q.size() == 0) break;
            g3 = got3_q.pop_front();
            check($sformatf("div3_byte%0d", i), 32'(g3), 32'(ref3[i]));
        end
        check("sclk_high_min_div3",  32'(hi3_min), 32'd3);
        check("sclk_high_max_div3",  32'(hi3_max), 32'd3);
        check("bit_period_min_div3", 32'(rr3_min), 32'd6);
        check("bit_period_max_div3", 32'(rr3_max), 32'd6);

        // Asynchronous reset in the middle of data byte 300, sclk high.
        c = 0;
        while (c < 8000) begin
            @(negedge clk);
            #1;
            if (addr1 == 10'd300 && sclk1 && m_bits >= 3) break;
            c++;
        end
        check("reached_byte300", 32'(c < 8000), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_cs",   32'(cs1),   32'd1);
        check("midrst_sclk", 32'(sclk1), 32'd0);
        check("midrst_addr", 32'(addr1), 32'd0);
        check("midrst_dc",   32'(dc1),   32'd0);
        check("midrst_sdin", 32'(sdin1), 32'd0);
        got_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) push_exp(1'b0, init_ref[i]);
        push_exp(1'b1, 8'h5A);
        drain(16, 2000, "reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
